stack_op_sequencer: RTL

STACK_OP_SEQUENCER -- requirements
Module: stack_op_sequencer

---
 rtl/stack_op_sequencer.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/stack_op_sequencer.sv
// Micro-sequencer that turns a small stack-machine opcode set into
// push/replace/pop/swap commands for an external register stack.
module stack_op_sequencer #(
  parameter int DEPTH = 16
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic                       instr_valid,
  output logic                       instr_ready,
  input  logic [3:0]                 opcode,
  input  logic [15:0]                imm,
  input  logic [15:0]                a,
  input  logic [15:0]                b,
  output logic [2:0]                 stackOP,
  output logic [15:0]                w,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       err,
  output logic [1:0]                 err_code
);

  localparam int DW = $clog2(DEPTH+1);
  localparam logic [DW-1:0] ONE = DW'(1);
  localparam logic [DW-1:0] TWO = DW'(2);

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_PUSH = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_POP  = 4'd6;
  localparam logic [3:0] OP_POP2 = 4'd7;
  localparam logic [3:0] OP_SWAP = 4'd8;
  localparam logic [3:0] OP_DUP  = 4'd9;
  localparam logic [3:0] OP_OVER = 4'd10;
  localparam logic [3:0] OP_ADDI = 4'd11;
  localparam logic [3:0] OP_CLR  = 4'd12;

  localparam logic [2:0] SO_NOP  = 3'd0;
  localparam logic [2:0] SO_PUSH = 3'd1;
  localparam logic [2:0] SO_REP  = 3'd2;
  localparam logic [2:0] SO_POP  = 3'd3;
  localparam logic [2:0] SO_POP2 = 3'd4;
  localparam logic [2:0] SO_SWAP = 3'd5;

  typedef enum logic [2:0] {
    IDLE,
    EXEC,
    STEP2,
    CLEAR,
    ERR
  } state_t;

  state_t      state;
  logic [3:0]  op_q;
  logic [15:0] imm_q;

  logic        illegal;
  logic        grows;
  logic [1:0]  need;
  logic        under;
  logic        over;

  always_comb begin
    illegal = 1'b0;
    grows   = 1'b0;
    need    = 2'd0;
    unique case (opcode)
      OP_ADD, OP_SUB, OP_OR, OP_SLT,
      OP_POP2, OP_SWAP: need = 2'd2;
      OP_OVER: begin
        need  = 2'd2;
        grows = 1'b1;
      end
      OP_POP: need = 2'd1;
      OP_DUP, OP_ADDI: begin
        need  = 2'd1;
        grows = 1'b1;
      end
      OP_PUSH: grows = 1'b1;
      OP_NOP, OP_CLR: begin
      end
      default: illegal = 1'b1;
    endcase
  end

  assign under = int'(depth) < int'(need);
  assign over  = grows && (int'(depth) == DEPTH);

  always_ff @(posedge CLK) begin
    if (reset) begin
      state    <= IDLE;
      depth    <= '0;
      err      <= 1'b0;
      err_code <= 2'd0;
      op_q     <= OP_NOP;
      imm_q    <= '0;
    end else begin
      unique case (state)
        IDLE: if (instr_valid) begin
          op_q  <= opcode;
          imm_q <= imm;
          if (illegal) begin
            state    <= ERR;
            err      <= 1'b1;
            err_code <= 2'd3;
          end else if (under) begin
            state    <= ERR;
            err      <= 1'b1;
            err_code <= 2'd1;
          end else if (over) begin
            state    <= ERR;
            err      <= 1'b1;
            err_code <= 2'd2;
          end else if (opcode == OP_CLR) begin
            state <= CLEAR;
          end else begin
            state <= EXEC;
          end
        end
        EXEC: begin
          state <= (op_q == OP_ADDI) ? STEP2 : IDLE;
          unique case (op_q)
            OP_PUSH, OP_DUP, OP_OVER, OP_ADDI:
              depth <= depth + ONE;
            OP_ADD, OP_SUB, OP_OR, OP_SLT, OP_POP:
              depth <= depth - ONE;
            OP_POP2:
              depth <= depth - TWO;
            default: begin
            end
          endcase
        end
        STEP2: begin
          depth <= depth - ONE;
          state <= IDLE;
        end
        // Leave in the same cycle the last entry is popped.
        CLEAR: begin
          if (depth != '0) depth <= depth - ONE;
          if (depth <= ONE) state <= IDLE;
        end
        ERR: state <= ERR;
        default: state <= IDLE;
      endcase
    end
  end

  assign instr_ready = (state == IDLE);

  always_comb begin
    stackOP = SO_NOP;
    w       = '0;
    unique case (state)
      EXEC: begin
        unique case (op_q)
          OP_PUSH, OP_ADDI: begin
            stackOP = SO_PUSH;
            w       = imm_q;
          end
          OP_ADD: begin
            stackOP = SO_REP;
            w       = b + a;
          end
          OP_SUB: begin
            stackOP = SO_REP;
            w       = b - a;
          end
          OP_OR: begin
            stackOP = SO_REP;
            w       = b | a;
          end
          OP_SLT: begin
            stackOP = SO_REP;
            w       = {15'd0, b < a};
          end
          OP_POP:  stackOP = SO_POP;
          OP_POP2: stackOP = SO_POP2;
          OP_SWAP: stackOP = SO_SWAP;
          OP_DUP: begin
            stackOP = SO_PUSH;
            w       = a;
          end
          OP_OVER: begin
            stackOP = SO_PUSH;
            w       = b;
          end
          default: begin
          end
        endcase
      end
      STEP2: begin
        stackOP = SO_REP;
        w       = b + a;
      end
      CLEAR: if (depth != '0) stackOP = SO_POP;
      default: begin
      end
    endcase
  end

endmodule
